// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, NOP encoding and PC stepping.
package cpu_pkg;

   // ADDI x0, x0, 0: canonical RISC-V NOP fed to IF/ID when no instruction is valid
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Sequential fetch increment, one 32-bit instruction word
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } fetch_state_t;

   // Force a PC onto a word boundary
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: consumed instructions and memory wait cycles.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_inc,
   input  logic        wait_inc,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_wait_cnt
);

   logic [31:0] fetch_cnt_q;
   logic [31:0] wait_cnt_q;

   // Free-running wrapping event counters, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         if (fetch_inc) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (wait_inc) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_wait_cnt  = wait_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one instruction-memory request outstanding, absorbs
// stalls and branch/jump redirects, and presents a NOP whenever no valid
// instruction is available.
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt / perf_wait_cnt outputs.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_wait_cnt,
`endif
   output logic [31:0] instruction_IF,
   output logic [31:0] pc_out,
   output logic        fetch_valid
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic         drop_q;
   logic [31:0]  instr_q;
   logic [31:0]  pc_out_q;
   logic         valid_q;

   // Consuming the held instruction and issuing the next request share one cycle
   logic         consume;

   assign consume = (state_q == S_HOLD) && !stall;

   // Request is combinational so a held instruction can be replaced back-to-back;
   // reset and redirect both block it so no request leaves with a stale PC
   always_comb begin
      imem_req = 1'b0;
      if (rst_n && !redirect_valid) begin
         imem_req = (state_q == S_ISSUE) || consume;
      end
   end

   assign imem_addr = pc_q;

   // Fetch FSM with registered IF/ID-facing outputs; redirect outranks everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_ISSUE;
         pc_q     <= align_pc(RESET_PC);
         drop_q   <= 1'b0;
         instr_q  <= NOP_INSTR;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else if (redirect_valid) begin
         pc_q    <= align_pc(redirect_pc);
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         if ((state_q == S_WAIT) && !imem_rvalid) begin
            // Response to the old path is still in flight; swallow it when it lands
            drop_q  <= 1'b1;
            state_q <= S_WAIT;
         end else begin
            drop_q  <= 1'b0;
            state_q <= S_ISSUE;
         end
      end else begin
         unique case (state_q)
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     state_q <= S_ISSUE;
                  end else begin
                     instr_q  <= imem_rdata;
                     pc_out_q <= pc_q;
                     valid_q  <= 1'b1;
                     pc_q     <= pc_q + PC_STEP;
                     state_q  <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            default: begin
               state_q <= S_ISSUE;
            end
         endcase
      end
   end

   assign instruction_IF = instr_q;
   assign pc_out         = pc_out_q;
   assign fetch_valid    = valid_q;

`ifdef FETCH_PERF_EN
   logic fetch_inc;
   logic wait_inc;

   assign fetch_inc = consume && !redirect_valid;
   assign wait_inc  = (state_q == S_WAIT) && !imem_rvalid;

   fetch_perf_cnt u_perf (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_inc      (fetch_inc),
      .wait_inc       (wait_inc),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_wait_cnt  (perf_wait_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small latency-configurable memory model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_IF;
   logic [31:0] pc_out;
   logic        fetch_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_wait_cnt;
`endif

   int          n_checks;
   int          n_fail;

   // Memory model state
   bit          mem_auto;
   int          mem_lat;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;

   fetch_stage #(
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_wait_cnt  (perf_wait_cnt),
`endif
      .instruction_IF (instruction_IF),
      .pc_out         (pc_out),
      .fetch_valid    (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'h0000_0104) return 32'hDEAD_BEEF;
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample request before the edge, update memory model after it
   task automatic step();
      logic        req_s;
      logic [31:0] addr_s;
      logic        rv_s;
      #1;
      req_s  = imem_req;
      addr_s = imem_addr;
      rv_s   = imem_rvalid;
      @(posedge clk);
      #1;
      if (mem_auto) begin
         if (rv_s) begin
            imem_rvalid = 1'b0;
            pend        = 1'b0;
         end
         if (req_s) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = addr_s;
         end
         if (pend && pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
            end
         end
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      mem_auto       = 1'b1;
      mem_lat        = 1;
      pend           = 1'b0;
      pend_cnt       = 0;
      pend_addr      = '0;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;

      // Reset state
      #1;
      check_eq("req_in_reset", imem_req, 0);
      step();
      step();
      check_eq("rst_valid", fetch_valid, 0);
      check_eq("rst_instr", instruction_IF, NOP);
      check_eq("rst_pc_out", pc_out, 0);
      check_eq("rst_req", imem_req, 0);

      // First fetch at RESET_PC, 1-cycle memory, 2-cycle cadence
      rst_n = 1'b1;
      #1;
      check_eq("first_req", imem_req, 1);
      check_eq("first_addr", imem_addr, 32'h100);
      step();
      check_eq("wait_req", imem_req, 0);
      check_eq("wait_valid", fetch_valid, 0);
      step();
      check_eq("f0_valid", fetch_valid, 1);
      check_eq("f0_pc", pc_out, 32'h100);
      check_eq("f0_instr", instruction_IF, 32'hC0DE_0100);
      check_eq("f0_next_req", imem_req, 1);
      check_eq("f0_next_addr", imem_addr, 32'h104);
      step();
      check_eq("bubble_valid", fetch_valid, 0);
      check_eq("bubble_instr", instruction_IF, NOP);
      step();
      check_eq("f1_valid", fetch_valid, 1);
      check_eq("f1_pc", pc_out, 32'h104);
      check_eq("f1_instr", instruction_IF, 32'hDEAD_BEEF);

      // Stall in S_HOLD for 3 cycles
      stall = 1'b1;
      #1;
      check_eq("stall_req0", imem_req, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_valid", fetch_valid, 1);
         check_eq("stall_pc", pc_out, 32'h104);
         check_eq("stall_instr", instruction_IF, 32'hDEAD_BEEF);
         check_eq("stall_req", imem_req, 0);
      end
      stall = 1'b0;
      #1;
      check_eq("unstall_req", imem_req, 1);
      check_eq("unstall_addr", imem_addr, 32'h108);
      step();
      step();
      check_eq("f2_valid", fetch_valid, 1);
      check_eq("f2_pc", pc_out, 32'h108);

      // Redirect while waiting; old response must be discarded
      mem_lat = 2;
      step();
      check_eq("rw_wait_valid", fetch_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2002;
      #1;
      check_eq("rw_req", imem_req, 0);
      step();
      redirect_valid = 1'b0;
      check_eq("rw_drop_valid", fetch_valid, 0);
      step();
      check_eq("rw_post_valid", fetch_valid, 0);
      check_eq("rw_post_instr", instruction_IF, NOP);
      check_eq("rw_issue_req", imem_req, 1);
      check_eq("rw_issue_addr", imem_addr, 32'h2000);
      step();
      check_eq("rw_w1_valid", fetch_valid, 0);
      step();
      check_eq("rw_w2_valid", fetch_valid, 0);
      step();
      check_eq("rw_f_valid", fetch_valid, 1);
      check_eq("rw_f_pc", pc_out, 32'h2000);
      check_eq("rw_f_instr", instruction_IF, 32'hC0DE_2000);

      // Redirect together with rvalid and stall
      step();
      step();
      check_eq("rr_rvalid_up", imem_rvalid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      stall          = 1'b1;
      #1;
      check_eq("rr_req", imem_req, 0);
      step();
      redirect_valid = 1'b0;
      #1;
      check_eq("rr_valid", fetch_valid, 0);
      check_eq("rr_instr", instruction_IF, NOP);
      check_eq("rr_issue_req", imem_req, 1);
      check_eq("rr_issue_addr", imem_addr, 32'h3000);
      step();
      step();
      step();
      check_eq("rr_f_valid", fetch_valid, 1);
      check_eq("rr_f_pc", pc_out, 32'h3000);
      check_eq("rr_f_instr", instruction_IF, 32'hC0DE_3000);
      check_eq("rr_hold_req", imem_req, 0);
      step();
      check_eq("rr_hold_pc", pc_out, 32'h3000);

      // Redirect from S_HOLD to unaligned top-of-memory, then PC wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      #1;
      check_eq("wrap_redir_req", imem_req, 0);
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      mem_lat        = 1;
      #1;
      check_eq("wrap_valid", fetch_valid, 0);
      check_eq("wrap_issue_req", imem_req, 1);
      check_eq("wrap_issue_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      step();
      check_eq("wrap_f_pc", pc_out, 32'hFFFF_FFFC);
      check_eq("wrap_f_instr", instruction_IF, 32'hC0DE_FFFC);
      check_eq("wrap_next_addr", imem_addr, 32'h0);

      // Reset mid-S_WAIT, stale rvalid right after release
      step();
      rst_n       = 1'b0;
      mem_auto    = 1'b0;
      imem_rvalid = 1'b0;
      pend        = 1'b0;
      #1;
      check_eq("mr_req", imem_req, 0);
      step();
      check_eq("mr_valid", fetch_valid, 0);
      check_eq("mr_instr", instruction_IF, NOP);
      check_eq("mr_pc_out", pc_out, 0);
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      #1;
      check_eq("mr_req_after", imem_req, 1);
      check_eq("mr_addr_after", imem_addr, 32'h100);
      step();
      imem_rvalid = 1'b0;
      check_eq("mr_stale_valid", fetch_valid, 0);
      check_eq("mr_stale_instr", instruction_IF, NOP);
      step();
      check_eq("mr_wait_valid", fetch_valid, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC0DE_0100;
      step();
      imem_rvalid = 1'b0;
      check_eq("mr_f_valid", fetch_valid, 1);
      check_eq("mr_f_pc", pc_out, 32'h100);
      check_eq("mr_f_instr", instruction_IF, 32'hC0DE_0100);

      // Five fetches at 2-cycle latency from a fresh reset
      mem_auto = 1'b1;
      mem_lat  = 2;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         step();
         check_eq("seq_valid", fetch_valid, 1);
         check_eq("seq_pc", pc_out, 32'h100 + 32'(4 * i));
         step();
      end
`ifdef FETCH_PERF_EN
      check_eq("perf_fetch", perf_fetch_cnt, 5);
      check_eq("perf_wait", perf_wait_cnt, 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
